// File: rtl/mc_control_if.sv
// Control/datapath bundle for the multicycle controller.
// master: the controller (drives strobes, selects, flags, state, fault).
// slave : the datapath/memory side (drives instr, flags_in, mem_ready).
interface mc_control_if;
    logic [31:0] instr;
    logic [3:0]  flags_in;
    logic        mem_ready;
    logic        pc_write;
    logic        ir_write;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic        adr_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic [1:0]  imm_src;
    logic [1:0]  reg_src;
    logic [2:0]  alu_control;
    logic [3:0]  flags;
    logic [3:0]  state;
    logic        fault;

    modport master (
        input  instr, flags_in, mem_ready,
        output pc_write, ir_write, reg_write, mem_write, mem_read, adr_src,
               alu_src_a, alu_src_b, result_src, imm_src, reg_src,
               alu_control, flags, state, fault
    );

    modport slave (
        output instr, flags_in, mem_ready,
        input  pc_write, ir_write, reg_write, mem_write, mem_read, adr_src,
               alu_src_a, alu_src_b, result_src, imm_src, reg_src,
               alu_control, flags, state, fault
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle ARM-subset controller: fetch/decode/memory/ALU/branch FSM with a
// memory wait-timeout that parks the machine in a sticky FAULT state.
// Optional feature: define MC_CONTROL_COND_EN to honour the instruction
// condition field; otherwise every instruction executes unconditionally.
module mc_control #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic         clk,
    input  logic         reset,
    mc_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_FAULT  = 4'd10
    } state_t;

    // The counter value seen on the cycle whose stall would make it TIMEOUT_CYC.
    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     r_state;
    logic [3:0] r_flags;
    logic       r_fault;
    logic [7:0] r_wait;

    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic       w_is_cmp;
    logic       w_cond_true;
    logic [2:0] w_alu_op;
    logic       w_unused;

    assign w_op     = bus.instr[27:26];
    assign w_funct  = bus.instr[25:20];
    assign w_is_cmp = (w_funct[4:1] == 4'b1010);

`ifdef MC_CONTROL_COND_EN
    logic [3:0] w_cond;
    logic       w_n, w_z, w_c, w_v;
    assign w_cond = bus.instr[31:28];
    assign {w_n, w_z, w_c, w_v} = r_flags;
    assign w_unused = ^bus.instr[19:0];

    // ARM condition table evaluated against the architectural flags.
    always_comb begin
        w_cond_true = 1'b0;
        case (w_cond)
            4'h0: w_cond_true = w_z;
            4'h1: w_cond_true = !w_z;
            4'h2: w_cond_true = w_c;
            4'h3: w_cond_true = !w_c;
            4'h4: w_cond_true = w_n;
            4'h5: w_cond_true = !w_n;
            4'h6: w_cond_true = w_v;
            4'h7: w_cond_true = !w_v;
            4'h8: w_cond_true = w_c && !w_z;
            4'h9: w_cond_true = !w_c || w_z;
            4'hA: w_cond_true = (w_n == w_v);
            4'hB: w_cond_true = (w_n != w_v);
            4'hC: w_cond_true = !w_z && (w_n == w_v);
            4'hD: w_cond_true = w_z || (w_n != w_v);
            4'hE: w_cond_true = 1'b1;
            default: w_cond_true = 1'b0;
        endcase
    end
`else
    assign w_cond_true = 1'b1;
    assign w_unused    = ^{bus.instr[31:28], bus.instr[19:0]};
`endif

    // Data-processing funct[4:1] to ALU operation; unknown codes fall back to ADD.
    always_comb begin
        w_alu_op = 3'b000;
        case (w_funct[4:1])
            4'b0100: w_alu_op = 3'b000;
            4'b0010: w_alu_op = 3'b001;
            4'b0000: w_alu_op = 3'b010;
            4'b1100: w_alu_op = 3'b011;
            4'b1010: w_alu_op = 3'b001;
            default: w_alu_op = 3'b000;
        endcase
    end

    // State, flags, fault and memory wait counter; completion beats timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_flags <= 4'b0000;
            r_fault <= 1'b0;
            r_wait  <= 8'd0;
        end else begin
            case (r_state)
                S_FETCH, S_MEMRD, S_MEMWR: begin
                    if (bus.mem_ready) begin
                        r_wait <= 8'd0;
                        if (r_state == S_FETCH)      r_state <= S_DECODE;
                        else if (r_state == S_MEMRD) r_state <= S_MEMWB;
                        else                         r_state <= S_FETCH;
                    end else if (r_wait == LP_WAIT_LAST) begin
                        r_wait  <= 8'd0;
                        r_fault <= 1'b1;
                        r_state <= S_FAULT;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (!w_cond_true) begin
                        r_state <= S_FETCH;
                    end else begin
                        case (w_op)
                            2'b01:   r_state <= S_MEMADR;
                            2'b10:   r_state <= S_BRANCH;
                            2'b00:   r_state <= w_funct[5] ? S_EXECI : S_EXECR;
                            default: r_state <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: r_state <= w_funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMWB:  r_state <= S_FETCH;
                S_EXECR,
                S_EXECI:  r_state <= S_ALUWB;
                S_ALUWB: begin
                    if (w_funct[0] || w_is_cmp) r_flags <= bus.flags_in;
                    r_state <= S_FETCH;
                end
                S_BRANCH: r_state <= S_FETCH;
                S_FAULT:  r_state <= S_FAULT;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Moore strobes/selects from state plus instr fields and mem_ready; forced low in reset and FAULT.
    always_comb begin
        bus.pc_write    = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_read    = 1'b0;
        bus.adr_src     = 1'b0;
        bus.alu_src_a   = 2'b00;
        bus.alu_src_b   = 2'b00;
        bus.result_src  = 2'b00;
        bus.imm_src     = 2'b00;
        bus.reg_src     = 2'b00;
        bus.alu_control = 3'b000;
        if (reset && (r_state != S_FAULT)) begin
            bus.imm_src = w_op;
            bus.reg_src = {(w_op == 2'b01) && !w_funct[0], (w_op == 2'b10)};
            case (r_state)
                S_FETCH: begin
                    bus.mem_read   = 1'b1;
                    bus.alu_src_a  = 2'b01;
                    bus.alu_src_b  = 2'b10;
                    bus.result_src = 2'b10;
                    bus.ir_write   = bus.mem_ready;
                    bus.pc_write   = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alu_src_a = 2'b01;
                    bus.alu_src_b = 2'b10;
                end
                S_MEMADR: bus.alu_src_b = 2'b01;
                S_MEMRD: begin
                    bus.mem_read = 1'b1;
                    bus.adr_src  = 1'b1;
                end
                S_MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.result_src = 2'b01;
                end
                S_MEMWR: begin
                    bus.mem_write = 1'b1;
                    bus.adr_src   = 1'b1;
                end
                S_EXECR: bus.alu_control = w_alu_op;
                S_EXECI: begin
                    bus.alu_src_b   = 2'b01;
                    bus.alu_control = w_alu_op;
                end
                S_ALUWB: begin
                    bus.alu_control = w_alu_op;
                    bus.reg_write   = !w_is_cmp;
                end
                S_BRANCH: begin
                    bus.alu_src_a  = 2'b01;
                    bus.alu_src_b  = 2'b01;
                    bus.result_src = 2'b10;
                    bus.pc_write   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.state = r_state;
    assign bus.flags = r_flags;
    assign bus.fault = r_fault;
endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: max cycles one memory access may wait for mem_ready (range 1..255).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-004 instr  input  32  current instruction: cond=[31:28], op=[27:26], funct=[25:20], rd=[15:12].
REQ-005 flags_in  input  4  ALU flags {N,Z,C,V} of the current ALU operation.
REQ-006 mem_ready  input  1  memory completes the access presented this cycle.
REQ-007 pc_write, ir_write, reg_write, mem_write, mem_read  output  1 each  datapath strobes.
REQ-008 adr_src  output  1  memory address select (0 = pc, 1 = ALU result).
REQ-009 alu_src_a, alu_src_b, result_src, imm_src, reg_src  output  2 each  datapath mux selects.
REQ-010 alu_control  output  3  operation: 000 ADD, 001 SUB, 010 AND, 011 ORR.
REQ-011 flags  output  4  architectural NZCV register.
REQ-012 state  output  4  current FSM state encoding; fault  output  1  sticky memory-timeout indicator.

Function
REQ-013 FSM states and encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, FAULT 10.
REQ-014 FETCH SHALL assert mem_read with adr_src=0 and hold until mem_ready=1; on that cycle, ir_write=1, pc_write=1 (pc+4), and next state is DECODE.
REQ-015 DECODE SHALL evaluate cond against flags: full ARM table; 1110 always true; 1111 never true. A false condition goes to FETCH with no other side effect.
REQ-016 Decode on true cond: op=01 goes to MEMADR; op=10 goes to BRANCH; op=00 goes to EXECI if funct[5]=1, else EXECR; op=11 goes to FETCH as a NOP.
REQ-017 Decode SHALL set imm_src=op and set reg_src[0]=1 for branch and reg_src[1]=1 for a store.
REQ-018 MEMADR SHALL compute base+imm (ADD). It goes to MEMRD if funct[0]=1, else to MEMWR.
REQ-019 MEMRD SHALL assert mem_read with adr_src=1 and wait for mem_ready, then go to MEMWB. MEMWB SHALL assert reg_write with result_src=01 (read data), then go to FETCH.
REQ-020 MEMWR SHALL assert mem_write with adr_src=1 and wait for mem_ready, then go to FETCH.
REQ-021 EXECR/EXECI SHALL map funct[4:1] as: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB). Any other value maps to ADD. Both states go to ALUWB.
REQ-022 ALUWB SHALL assert reg_write (result_src=00) except for CMP.
REQ-023 ALUWB SHALL load flags from flags_in when funct[0]=1 or on CMP; flags are otherwise unchanged.
REQ-024 BRANCH SHALL assert pc_write with result_src=10 (ALU target), then go to FETCH.
REQ-025 A wait counter SHALL count cycles in FETCH/MEMRD/MEMWR while mem_ready=0 and SHALL clear on state exit.
REQ-026 When the wait counter reaches TIMEOUT_CYC, the FSM SHALL enter FAULT with fault=1 and no strobes; it leaves FAULT only by reset.
REQ-027 mem_ready=1 on the same cycle the counter reaches TIMEOUT_CYC SHALL complete the access; completion has priority over the timeout.
REQ-028 Strobes SHALL be Moore outputs of state, plus decoded instr fields and mem_ready. At most one of mem_read/mem_write SHALL be high in any cycle.

Reset
REQ-029 While reset=0: state=FETCH, flags=0000, fault=0, wait counter=0, and all strobes=0 regardless of state.
REQ-030 Reset asserted mid-access SHALL abandon the access. Fetch restarts on the first clk edge after reset release.

Configuration
REQ-031 With macro MC_CONTROL_COND_EN defined, conditional execution SHALL follow REQ-015.
REQ-032 Without MC_CONTROL_COND_EN, every cond SHALL be treated as true, and flags still update per REQ-023.

Verification
REQ-033 ADD r1 (cond 1110, I=1, S=1), mem_ready=1 always -> states 0,1,7,8,0. reg_write=1 in state 8; flags equal flags_in of that cycle.
REQ-034 LDR with mem_ready low 3 cycles in MEMRD -> state holds 3 at 3 extra cycles, then 4; reg_write with result_src=01 exactly once.
REQ-035 BEQ with flags Z=0 -> DECODE to FETCH, no BRANCH; same with Z=1 -> BRANCH with pc_write=1, result_src=10.
REQ-036 TIMEOUT_CYC=4, mem_ready held low in FETCH -> state=10 and fault=1 after 4 wait cycles, with all strobes 0. Reset then returns state 0 and fault 0.
REQ-037 CMP with S=0 -> flags updated in ALUWB and reg_write stays 0. Reset asserted during MEMWR -> mem_write drops immediately.
